// File: rtl/reg_wb_arbiter.sv
// Write-side master for the register file: merges never-stalled ALU results with
// FIFO-buffered load results and tracks which registers still have loads pending.
module reg_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               alu_valid,
  input  logic [AW-1:0]      alu_rd,
  input  logic [DW-1:0]      alu_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_rd,
  input  logic [DW-1:0]      ld_data,
  output logic               Wen,
  output logic [AW-1:0]      Wd,
  output logic [DW-1:0]      Wdat,
  output logic [2**AW-1:0]   busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**AW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Load FIFO. An entry is occupied when it lies between rd_ptr and wr_ptr;
  // live is cleared on pop, so live alone marks a pending write.
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             wen_q, wen_d;
  logic [AW-1:0]    wd_q, wd_d;
  logic [DW-1:0]    wdat_q, wdat_d;

  logic push, pop, head_live;

  assign ld_ready  = (count_q != FULL_CNT);
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_valid && (count_q != '0);
  assign head_live = live_q[rd_ptr_q];

  always_comb begin
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wen_d    = 1'b0;
    wd_d     = wd_q;
    wdat_d   = wdat_q;

    if (alu_valid) begin
      wen_d  = 1'b1;
      wd_d   = alu_rd;
      wdat_d = alu_data;
      // Queued loads to the same register are older than this ALU write.
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
      end
    end else if (pop) begin
      wen_d = head_live;
      if (head_live) begin
        wd_d   = rd_q[rd_ptr_q];
        wdat_d = data_q[rd_ptr_q];
      end
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    if (push) begin
      live_d[wr_ptr_q] = !(alu_valid && (ld_rd == alu_rd));
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      wd_q     <= '0;
      wdat_q   <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      wd_q     <= wd_d;
      wdat_q   <= wdat_d;
    end
  end

  // NOTE: the payload array is deliberately not reset; live_q gates every read of
  // it, so leaving it reset-free lets it map onto plain storage.
  always_ff @(posedge Clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= ld_rd;
      data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) busy[rd_q[i]] = 1'b1;
    end
  end

  assign Wen  = wen_q;
  assign Wd   = wd_q;
  assign Wdat = wdat_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_reg_wb_arbiter;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       alu_valid;
  logic [2:0] alu_rd;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_rd;
  logic [7:0] ld_data;
  logic       Wen;
  logic [2:0] Wd;
  logic [7:0] Wdat;
  logic [7:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  reg_wb_arbiter #(.DEPTH(4), .DW(8), .AW(3)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .Wen       (Wen),
    .Wd        (Wd),
    .Wdat      (Wdat),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [2:0] a, input logic [7:0] d);
    chk({tag, ".wen"}, 32'(Wen), 32'(en));
    if (en) begin
      chk({tag, ".wd"},   32'(Wd),   32'(a));
      chk({tag, ".wdat"}, 32'(Wdat), 32'(d));
    end
  endtask

  // Sample 1 time unit after the rising edge; inputs are changed after sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  initial begin
    logic [7:0] exp_busy;

    // 1. Reset with random inputs
    Reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst.wen",   32'(Wen),      32'h0);
      chk("rst.busy",  32'(busy),     32'h0);
      chk("rst.ready", 32'(ld_ready), 32'h1);
      alu_valid = 1'($urandom); alu_rd = 3'($urandom); alu_data = 8'($urandom);
      ld_valid  = 1'($urandom); ld_rd  = 3'($urandom); ld_data  = 8'($urandom);
    end
    tick();
    chk("rst.wd",   32'(Wd),   32'h0);
    chk("rst.wdat", 32'(Wdat), 32'h0);
    idle_inputs();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("idle", 1'b0, 3'd0, 8'h00);
    end
    chk("idle.busy", 32'(busy), 32'h0);

    // 2. Single ALU write
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 8'h5A;
    tick();
    alu_valid = 1'b0;
    chk_wr("alu", 1'b1, 3'd3, 8'h5A);
    tick();
    chk_wr("alu.after", 1'b0, 3'd0, 8'h00);
    chk("alu.hold_wd",   32'(Wd),   32'h3);
    chk("alu.hold_wdat", 32'(Wdat), 32'h5A);

    // 3. Single load into an idle arbiter
    ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 8'h11;
    tick();
    ld_valid = 1'b0;
    chk_wr("ld.accept", 1'b0, 3'd0, 8'h00);
    chk("ld.busy", 32'(busy), 32'h04);
    tick();
    chk_wr("ld.write", 1'b1, 3'd2, 8'h11);
    chk("ld.busy_clear", 32'(busy), 32'h00);
    tick();
    chk_wr("ld.after", 1'b0, 3'd0, 8'h00);

    // 4. Fill FIFO behind continuous ALU traffic, then drain in order
    exp_busy = 8'h00;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'hC0 + 8'(i);
      ld_valid  = 1'b1; ld_rd  = 3'(4 + i); ld_data = 8'h40 + 8'(i);
      tick();
      exp_busy = exp_busy | (8'h10 << i);
      chk_wr("fill.alu", 1'b1, 3'd1, 8'hC0 + 8'(i));
      chk("fill.busy",  32'(busy),     32'(exp_busy));
      chk("fill.ready", 32'(ld_ready), 32'(i < 3));
    end
    alu_data = 8'hC4; ld_rd = 3'd0; ld_data = 8'h99;
    tick();
    chk_wr("full.alu", 1'b1, 3'd1, 8'hC4);
    chk("full.busy",  32'(busy),     32'hF0);
    chk("full.ready", 32'(ld_ready), 32'h0);
    alu_valid = 1'b0;
    tick();
    ld_valid = 1'b0;
    chk_wr("drain0", 1'b1, 3'd4, 8'h40);
    chk("drain0.ready", 32'(ld_ready), 32'h1);
    chk("drain0.busy",  32'(busy),     32'hE0);
    tick();
    chk_wr("drain1", 1'b1, 3'd5, 8'h41);
    chk("drain1.busy", 32'(busy), 32'hC0);
    tick();
    chk_wr("drain2", 1'b1, 3'd6, 8'h42);
    chk("drain2.busy", 32'(busy), 32'h80);
    tick();
    chk_wr("drain3", 1'b1, 3'd7, 8'h43);
    chk("drain3.busy", 32'(busy), 32'h00);
    tick();
    chk_wr("drain.end", 1'b0, 3'd0, 8'h00);

    // 5. WAW kill of an already-queued load
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 8'h01;
    ld_valid  = 1'b1; ld_rd  = 3'd5; ld_data  = 8'hAA;
    tick();
    chk_wr("waw.q", 1'b1, 3'd0, 8'h01);
    chk("waw.q.busy", 32'(busy), 32'h20);
    alu_rd = 3'd5; alu_data = 8'h33; ld_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    chk_wr("waw.alu", 1'b1, 3'd5, 8'h33);
    chk("waw.busy", 32'(busy), 32'h00);
    tick();
    chk_wr("waw.deadpop", 1'b0, 3'd0, 8'h00);
    tick();
    chk_wr("waw.idle", 1'b0, 3'd0, 8'h00);
    ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 8'h22;
    tick();
    ld_valid = 1'b0;
    chk("waw.empty.busy", 32'(busy), 32'h04);
    tick();
    chk_wr("waw.empty.write", 1'b1, 3'd2, 8'h22);

    // 6a. Same-cycle ALU and load to one register: load stored dead
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 8'h66;
    ld_valid  = 1'b1; ld_rd  = 3'd6; ld_data  = 8'hBB;
    tick();
    idle_inputs();
    chk_wr("same.alu", 1'b1, 3'd6, 8'h66);
    chk("same.busy", 32'(busy), 32'h00);
    tick();
    chk_wr("same.deadpop", 1'b0, 3'd0, 8'h00);
    tick();
    chk_wr("same.idle", 1'b0, 3'd0, 8'h00);

    // 6b. Async reset in the middle of a 3-entry drain
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 8'hE0 + 8'(i);
      ld_valid  = 1'b1; ld_rd  = 3'(1 + i); ld_data = 8'hD1 + 8'(i);
      tick();
    end
    idle_inputs();
    chk("mid.busy", 32'(busy), 32'h0E);
    tick();
    chk_wr("mid.pop0", 1'b1, 3'd1, 8'hD1);
    chk("mid.pop0.busy", 32'(busy), 32'h0C);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid.rst.wen",   32'(Wen),      32'h0);
    chk("mid.rst.wd",    32'(Wd),       32'h0);
    chk("mid.rst.wdat",  32'(Wdat),     32'h0);
    chk("mid.rst.busy",  32'(busy),     32'h00);
    chk("mid.rst.ready", 32'(ld_ready), 32'h1);
    tick();
    chk_wr("mid.rst.hold", 1'b0, 3'd0, 8'h00);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("mid.post", 1'b0, 3'd0, 8'h00);
      chk("mid.post.busy", 32'(busy), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
